// File: rtl/pad_owner_switch.sv
// Pad-group owner switch: hands one PAD_W-bit pad group between NUM_SRC controllers
// through a drain -> guard -> handover sequence, so pads never see a cut transfer.
//
// state   | meaning
// S_OWN   | owner drives pads (registered), watching sel_i for a change request
// S_DRAIN | owner keeps pads until its busy drops or the drain timer expires
// S_GUARD | pads held at the idle pattern for GUARD_CYC cycles, then ownership moves
module pad_owner_switch #(
  parameter int               NUM_SRC   = 2,
  parameter int               PAD_W     = 6,
  parameter int               GUARD_CYC = 4,
  parameter int               DRAIN_MAX = 1024,
  parameter int               RST_OWNER = 0,
  parameter logic [PAD_W-1:0] IDLE_OUT  = '1,
  parameter logic [PAD_W-1:0] IDLE_OE   = '0,
  parameter logic [PAD_W-1:0] IDLE_IN   = '1,
  parameter int               SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1  // derived
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [NUM_SRC*PAD_W-1:0] src_out_i,
  input  logic [NUM_SRC*PAD_W-1:0] src_oe_i,
  input  logic [NUM_SRC-1:0]       src_busy_i,
  output logic [NUM_SRC*PAD_W-1:0] src_in_o,
  input  logic [PAD_W-1:0]         pad_in_i,
  output logic [PAD_W-1:0]         pad_out_o,
  output logic [PAD_W-1:0]         pad_oe_o,
  output logic [SEL_W-1:0]         owner_o,
  output logic                     switching_o,
  output logic                     sw_done_o,
  output logic                     timeout_o,
  output logic                     sel_err_o
);

  localparam int DRAIN_W = $clog2(DRAIN_MAX + 1);
  localparam int GUARD_W = $clog2(GUARD_CYC + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYC - 1);

  typedef enum logic [1:0] {S_OWN, S_DRAIN, S_GUARD} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [SEL_W-1:0]   target_q, target_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
  logic [PAD_W-1:0]   pad_out_q, pad_out_d;
  logic [PAD_W-1:0]   pad_oe_q, pad_oe_d;
  logic               sw_done_q, sw_done_d;
  logic               timeout_q, timeout_d;

  logic               sel_valid;
  logic [PAD_W-1:0]   own_out;
  logic [PAD_W-1:0]   own_oe;
  logic               own_busy;

  // Widened compare keeps the check meaningful when NUM_SRC is a power of two.
  assign sel_valid = ({1'b0, sel_i} < (SEL_W + 1)'(NUM_SRC));
  assign sel_err_o = ~sel_valid;

  always_comb begin
    own_out  = '0;
    own_oe   = '0;
    own_busy = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (owner_q == SEL_W'(k)) begin
        own_out  = src_out_i[k*PAD_W +: PAD_W];
        own_oe   = src_oe_i[k*PAD_W +: PAD_W];
        own_busy = src_busy_i[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      src_in_o[k*PAD_W +: PAD_W] = ((state_q != S_GUARD) && (owner_q == SEL_W'(k))) ?
                                   pad_in_i : IDLE_IN;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    target_d    = target_q;
    drain_cnt_d = drain_cnt_q;
    guard_cnt_d = guard_cnt_q;
    sw_done_d   = 1'b0;
    timeout_d   = 1'b0;
    pad_out_d   = own_out;
    pad_oe_d    = own_oe;
    case (state_q)
      S_OWN: begin
        if (sel_valid && (sel_i != owner_q)) begin
          target_d    = sel_i;
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (sel_valid && (sel_i == owner_q)) begin
          state_d = S_OWN;
        end else begin
          if (sel_valid && (sel_i != target_q)) target_d = sel_i;
          // A busy drop wins over an expiring drain timer in the same cycle.
          if (!own_busy) begin
            guard_cnt_d = '0;
            state_d     = S_GUARD;
          end else if (drain_cnt_q == DRAIN_LAST) begin
            timeout_d   = 1'b1;
            guard_cnt_d = '0;
            state_d     = S_GUARD;
          end else begin
            drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
          end
        end
      end
      S_GUARD: begin
        pad_out_d = IDLE_OUT;
        pad_oe_d  = IDLE_OE;
        if (sel_valid && (sel_i != target_q)) begin
          target_d    = sel_i;
          guard_cnt_d = '0;
        end else if (guard_cnt_q == GUARD_LAST) begin
          owner_d   = target_q;
          sw_done_d = 1'b1;
          state_d   = S_OWN;
        end else begin
          guard_cnt_d = guard_cnt_q + GUARD_W'(1);
        end
      end
      default: state_d = S_OWN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_OWN;
      owner_q     <= SEL_W'(RST_OWNER);
      target_q    <= SEL_W'(RST_OWNER);
      drain_cnt_q <= '0;
      guard_cnt_q <= '0;
      pad_out_q   <= IDLE_OUT;
      pad_oe_q    <= IDLE_OE;
      sw_done_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      target_q    <= target_d;
      drain_cnt_q <= drain_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      pad_out_q   <= pad_out_d;
      pad_oe_q    <= pad_oe_d;
      sw_done_q   <= sw_done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pad_out_o   = pad_out_q;
  assign pad_oe_o    = pad_oe_q;
  assign owner_o     = owner_q;
  assign switching_o = (state_q == S_DRAIN) || (state_q == S_GUARD);
  assign sw_done_o   = sw_done_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pad_owner_switch.sv
// Directed bench for pad_owner_switch: a 4-source instance (short drain timer) and
// a 3-source instance for out-of-range select and reset during the guard window.
module tb_pad_owner_switch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_to    = 0;

  // instance a: NUM_SRC=4, DRAIN_MAX=16
  logic        a_rst;
  logic [1:0]  a_sel;
  logic [23:0] a_src_out, a_src_oe, a_src_in;
  logic [3:0]  a_busy;
  logic [5:0]  a_pad_in, a_pad_out, a_pad_oe;
  logic [1:0]  a_owner;
  logic        a_switching, a_sw_done, a_timeout, a_sel_err;

  // instance c: NUM_SRC=3, default DRAIN_MAX
  logic        c_rst;
  logic [1:0]  c_sel;
  logic [17:0] c_src_out, c_src_oe, c_src_in;
  logic [2:0]  c_busy;
  logic [5:0]  c_pad_in, c_pad_out, c_pad_oe;
  logic [1:0]  c_owner;
  logic        c_switching, c_sw_done, c_timeout, c_sel_err;

  pad_owner_switch #(.NUM_SRC(4), .PAD_W(6), .GUARD_CYC(4), .DRAIN_MAX(16)) u_a (
    .clk_i(clk), .rst_i(a_rst), .sel_i(a_sel),
    .src_out_i(a_src_out), .src_oe_i(a_src_oe), .src_busy_i(a_busy),
    .src_in_o(a_src_in), .pad_in_i(a_pad_in),
    .pad_out_o(a_pad_out), .pad_oe_o(a_pad_oe), .owner_o(a_owner),
    .switching_o(a_switching), .sw_done_o(a_sw_done), .timeout_o(a_timeout),
    .sel_err_o(a_sel_err)
  );

  pad_owner_switch #(.NUM_SRC(3), .PAD_W(6), .GUARD_CYC(4)) u_c (
    .clk_i(clk), .rst_i(c_rst), .sel_i(c_sel),
    .src_out_i(c_src_out), .src_oe_i(c_src_oe), .src_busy_i(c_busy),
    .src_in_o(c_src_in), .pad_in_i(c_pad_in),
    .pad_out_o(c_pad_out), .pad_oe_o(c_pad_oe), .owner_o(c_owner),
    .switching_o(c_switching), .sw_done_o(c_sw_done), .timeout_o(c_timeout),
    .sel_err_o(c_sel_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; registered outputs are stable 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst = 1'b1; a_sel = 2'd0; a_busy = '0; a_pad_in = 6'h2A;
    a_src_out = '0; a_src_oe = '0;
    c_rst = 1'b1; c_sel = 2'd0; c_busy = '0; c_pad_in = 6'h11;
    c_src_out = '0; c_src_oe = '0;

    // reset state
    step(); step();
    chk("rst_owner", a_owner, 0);
    chk("rst_pad_oe", a_pad_oe, 6'h00);
    chk("rst_pad_out", a_pad_out, 6'h3F);
    chk("rst_switching", a_switching, 0);
    chk("rst_sw_done", a_sw_done, 0);
    chk("rst_timeout", a_timeout, 0);
    a_rst = 1'b0; c_rst = 1'b0;
    a_src_out[0 +: 6]  = 6'h15; a_src_oe[0 +: 6]  = 6'h3F;
    a_src_out[6 +: 6]  = 6'h0C; a_src_oe[6 +: 6]  = 6'h21;
    a_src_out[12 +: 6] = 6'h07; a_src_oe[12 +: 6] = 6'h07;
    a_src_out[18 +: 6] = 6'h33; a_src_oe[18 +: 6] = 6'h1E;
    c_src_out[0 +: 6]  = 6'h2D; c_src_oe[0 +: 6]  = 6'h0F;
    step();
    chk("own0_pad_out", a_pad_out, 6'h15);
    chk("own0_pad_oe", a_pad_oe, 6'h3F);
    #1 chk("own0_src_in", a_src_in, 24'hFFFFEA);

    // clean switch 0 -> 1, busy low (cycle t)
    a_sel = 2'd1;
    #1 chk("sel1_err", a_sel_err, 0);
    step(); // t+1 DRAIN
    chk("clean_t1_sw", a_switching, 1);
    chk("clean_t1_owner", a_owner, 0);
    chk("clean_t1_pad", a_pad_out, 6'h15);
    step(); // t+2 GUARD
    chk("clean_t2_sw", a_switching, 1);
    chk("clean_t2_src_in", a_src_in, 24'hFFFFFF);
    step(); // t+3
    chk("clean_t3_pad_oe", a_pad_oe, 6'h00);
    chk("clean_t3_pad_out", a_pad_out, 6'h3F);
    step(); step(); // t+5
    chk("clean_t5_sw", a_switching, 1);
    chk("clean_t5_done", a_sw_done, 0);
    chk("clean_t5_pad_oe", a_pad_oe, 6'h00);
    step(); // t+6
    chk("clean_t6_done", a_sw_done, 1);
    chk("clean_t6_owner", a_owner, 1);
    chk("clean_t6_sw", a_switching, 0);
    chk("clean_t6_src_in", a_src_in, 24'hFFFABF);
    step(); // t+7
    chk("clean_t7_done", a_sw_done, 0);
    chk("clean_t7_pad_out", a_pad_out, 6'h0C);
    chk("clean_t7_pad_oe", a_pad_oe, 6'h21);

    // busy hold: owner 1 busy for 10 cycles while switching to 0
    a_sel = 2'd0; a_busy[1] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("hold_sw", a_switching, 1);
      chk("hold_pad_out", a_pad_out, 6'h0C);
      chk("hold_timeout", a_timeout, 0);
    end
    a_busy[1] = 1'b0;
    step();
    chk("hold_guard_pad", a_pad_out, 6'h0C);
    chk("hold_guard_timeout", a_timeout, 0);
    step();
    chk("hold_guard_idle", a_pad_out, 6'h3F);
    step(); step();
    chk("hold_guard_done0", a_sw_done, 0);
    step();
    chk("hold_done", a_sw_done, 1);
    chk("hold_owner", a_owner, 0);
    step();
    chk("hold_pad_new", a_pad_out, 6'h15);

    // timeout: owner 0 stuck busy, target 3, DRAIN_MAX=16
    a_sel = 2'd3; a_busy[0] = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (a_timeout) n_to++;
      chk("to_drain_pad", a_pad_out, 6'h15);
    end
    step();
    if (a_timeout) n_to++;
    chk("to_pulse", a_timeout, 1);
    chk("to_pulse_sw", a_switching, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (a_timeout) n_to++;
    end
    chk("to_guard_done0", a_sw_done, 0);
    step();
    if (a_timeout) n_to++;
    chk("to_done", a_sw_done, 1);
    chk("to_owner", a_owner, 3);
    chk("to_pulse_count", n_to, 1);
    a_busy[0] = 1'b0;

    // abort: owner 3 busy, request 1, then back to 3 during DRAIN
    a_sel = 2'd1; a_busy[3] = 1'b1;
    step();
    chk("abort_drain_sw", a_switching, 1);
    chk("abort_drain_pad", a_pad_out, 6'h33);
    a_sel = 2'd3;
    step();
    chk("abort_sw", a_switching, 0);
    chk("abort_owner", a_owner, 3);
    chk("abort_done", a_sw_done, 0);
    step();
    chk("abort_done_late", a_sw_done, 0);
    chk("abort_pad", a_pad_out, 6'h33);

    // retarget in GUARD: 3 -> 1, then -> 2 in the second guard cycle (w)
    a_busy[3] = 1'b0; a_sel = 2'd1;
    step(); step(); step(); // w+3, GUARD count 1
    chk("rt_guard_sw", a_switching, 1);
    a_sel = 2'd2;
    step(); step(); step(); // w+6
    chk("rt_w6_sw", a_switching, 1);
    chk("rt_w6_done", a_sw_done, 0);
    chk("rt_w6_owner", a_owner, 3);
    step(); step(); // w+8
    chk("rt_done", a_sw_done, 1);
    chk("rt_owner", a_owner, 2);
    chk("rt_src_in", a_src_in, 24'hFEAFFF);

    // instance c: out-of-range select is ignored
    step();
    chk("c_pad_own0", c_pad_out, 6'h2D);
    c_sel = 2'd3;
    #1 chk("c_sel_err", c_sel_err, 1);
    step(); step();
    chk("c_inv_sw", c_switching, 0);
    chk("c_inv_owner", c_owner, 0);
    chk("c_inv_pad", c_pad_out, 6'h2D);
    c_sel = 2'd2; // cycle x
    #1 chk("c_sel_ok", c_sel_err, 0);
    step(); step(); step(); // x+3, GUARD
    chk("c_guard_sw", c_switching, 1);
    chk("c_guard_pad", c_pad_out, 6'h3F);
    c_rst = 1'b1;
    step();
    chk("c_rst_owner", c_owner, 0);
    chk("c_rst_sw", c_switching, 0);
    chk("c_rst_pad_out", c_pad_out, 6'h3F);
    chk("c_rst_pad_oe", c_pad_oe, 6'h00);
    chk("c_rst_done", c_sw_done, 0);
    c_rst = 1'b0; c_sel = 2'd0;
    step();
    chk("c_after_rst_pad", c_pad_out, 6'h2D);
    chk("c_after_rst_sw", c_switching, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
